// File: rtl/ssp_tx.sv
// ssp_tx: serialises parallel words onto an SSP-style link to the ARM.
// Each word goes MSB first; every bit period is 2*HALF pck0 cycles,
// with ssp_clk high for the first half and low for the second.
// Ports:
//   pck0       - sole clock, rising edge
//   rst        - asynchronous active-high reset
//   data_in    - word to transmit (DATA_W bits)
//   data_valid - data_in valid this cycle
//   data_ready - block accepts data_in this cycle (combinational)
//   ssp_clk    - serial clock to the ARM (registered)
//   ssp_frame  - high for the first bit period of each word (registered)
//   ssp_din    - serial data, MSB first (registered)
//   word_done  - one-cycle pulse after the last bit of a word (registered)
module ssp_tx #(
    parameter int DATA_W = 8,
    parameter int HALF   = 2
) (
    input  logic              pck0,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              ssp_clk,
    output logic              ssp_frame,
    output logic              ssp_din,
    output logic              word_done
);

    localparam int HW = $clog2(HALF + 1);
    localparam int BW = $clog2(DATA_W);

    localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
    localparam logic [BW-1:0] BIT_FIRST = BW'(DATA_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [HW-1:0]     half_q, half_d;
    logic              clk_q, clk_d;
    logic              frame_q, frame_d;
    logic              din_q, din_d;
    logic              done_q, done_d;

    logic              half_end;
    logic              last_cycle;
    logic              xfer;
    logic              load;

    // Final cycle of bit 0: low half of the clock, half counter expired.
    assign half_end   = (half_q == HALF_LAST);
    assign last_cycle = (state_q == SHIFT) && !clk_q && half_end
                        && (bit_q == '0);
    assign data_ready = (state_q == IDLE) || last_cycle;
    assign xfer       = data_valid && data_ready;

    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            half_q  <= '0;
            clk_q   <= 1'b0;
            frame_q <= 1'b0;
            din_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            clk_q   <= clk_d;
            frame_q <= frame_d;
            din_q   <= din_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        half_d  = half_q;
        clk_d   = clk_q;
        frame_d = frame_q;
        din_d   = din_q;
        done_d  = 1'b0;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                load = xfer;
            end
            SHIFT: begin
                if (!half_end) begin
                    half_d = half_q + 1'b1;
                end else begin
                    half_d = '0;
                    if (clk_q) begin
                        clk_d = 1'b0;
                    end else if (bit_q != '0) begin
                        // Next bit starts: data changes with the clock rise.
                        bit_d   = bit_q - 1'b1;
                        clk_d   = 1'b1;
                        frame_d = 1'b0;
                        din_d   = shreg_q[DATA_W-1];
                        shreg_d = shreg_q << 1;
                    end else begin
                        done_d = 1'b1;
                        if (xfer) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            shreg_d = '0;
                            bit_d   = '0;
                            clk_d   = 1'b0;
                            frame_d = 1'b0;
                            din_d   = 1'b0;
                        end
                    end
                end
            end
        endcase

        // The MSB goes straight to ssp_din; the rest waits in shreg.
        if (load) begin
            state_d = SHIFT;
            bit_d   = BIT_FIRST;
            half_d  = '0;
            clk_d   = 1'b1;
            frame_d = 1'b1;
            din_d   = data_in[DATA_W-1];
            shreg_d = data_in << 1;
        end
    end

    assign ssp_clk   = clk_q;
    assign ssp_frame = frame_q;
    assign ssp_din   = din_q;
    assign word_done = done_q;

endmodule

// File: doc/ssp_tx.md
SSP_TX -- requirements
Module: ssp_tx

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits; legal range 2..32.
REQ-002 Parameter HALF, default 2: pck0 cycles per ssp_clk half-period; legal range 1..255.
REQ-003 pck0  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  DATA_W  word to transmit to the ARM.
REQ-006 data_valid  input  1  data_in is valid this cycle.
REQ-007 data_ready  output  1  block accepts data_in this cycle.
REQ-008 ssp_clk  output  1  serial clock to the ARM.
REQ-009 ssp_frame  output  1  frame sync; high during the first bit of each word.
REQ-010 ssp_din  output  1  serial data to the ARM, MSB first.
REQ-011 word_done  output  1  one-cycle pulse when the last bit of a word completes.

Function
REQ-012 States SHALL be IDLE and SHIFT only.
REQ-013 Transfer SHALL occur on a pck0 rising edge when data_valid and data_ready are both 1; data_in SHALL be latched on that edge.
REQ-014 data_ready SHALL be 1 in IDLE, and 1 in the final pck0 cycle of the last bit in SHIFT, and 0 otherwise.
REQ-015 IDLE with transfer: next state SHALL be SHIFT, bit index DATA_W-1, half counter 0.
REQ-016 Each bit period SHALL last exactly 2*HALF pck0 cycles: ssp_clk=1 for the first HALF cycles and ssp_clk=0 for the last HALF cycles.
REQ-017 ssp_din SHALL change only at bit-period start, coincident with the ssp_clk rise, and SHALL hold for the whole bit; the ARM samples on the ssp_clk fall.
REQ-018 Latency: the cycle after the accepting edge SHALL show ssp_clk=1, ssp_frame=1 and ssp_din=data_in[DATA_W-1].
REQ-019 ssp_frame SHALL be 1 for exactly the first bit period (2*HALF cycles) of every word, and 0 otherwise.
REQ-020 Bits SHALL be sent MSB first, from index DATA_W-1 down to 0.
REQ-021 At the end of bit 0:
- word_done SHALL pulse high for 1 cycle, in the cycle after the last bit's final cycle.
- If a transfer occurred on that edge, the block SHALL stay in SHIFT and the next word's first bit SHALL begin immediately, with no gap cycle and with ssp_frame=1.
- Otherwise the block SHALL return to IDLE.
REQ-022 In IDLE, ssp_clk, ssp_frame and ssp_din SHALL all be 0.
REQ-023 data_valid in SHIFT outside the final cycle SHALL be ignored, and data_in SHALL NOT be sampled.
REQ-024 All outputs except data_ready SHALL come straight from flip-flops, with no combinational path from inputs.
REQ-025 The half counter SHALL be sized ceil(log2(HALF+1)) bits, and the bit index ceil(log2(DATA_W)) bits; neither SHALL wrap during a word.

Reset
REQ-026 While rst=1, the block SHALL be asynchronously forced to IDLE with:
- ssp_clk=0, ssp_frame=0, ssp_din=0, word_done=0;
- data_ready=1;
- counters and shift register cleared.
REQ-027 Reset during SHIFT SHALL abort the word; no word_done SHALL be generated for it.
REQ-028 The first transfer SHALL be possible on the first rising edge after rst falls.

Verification
REQ-029 DATA_W=8, HALF=2, data_in=0xA5 with one valid pulse -> 32 cycles of ssp_clk pattern 1100 repeated 8 times; ssp_din bits 1,0,1,0,0,1,0,1; ssp_frame high for cycles 1-4 only; word_done on cycle 33; data_ready high again after that.
REQ-030 data_valid held high with 0x01 then 0xFF (HALF=1) -> 16 contiguous bit periods with no idle cycle; ssp_frame high in periods 1 and 9; word_done pulses twice, 8 bit periods apart.
REQ-031 data_in changed to 0x00 mid-word with data_valid=1 -> the transmitted word is unchanged and data_ready stays 0 until the final cycle.
REQ-032 rst asserted during bit 3 of 0xC3 -> all outputs 0 and data_ready=1 immediately, with no word_done; a following 0x3C transmits correctly from its MSB.
REQ-033 DATA_W=16, HALF=3, data_in=0x8001 -> 96 cycles; ssp_din high only in bit periods 1 and 16; ssp_frame high for 6 cycles.
REQ-034 Idle bench with data_valid=0 for 100 cycles -> ssp_clk, ssp_frame, ssp_din and word_done stay 0, and data_ready stays 1.
